// File: rtl/tlc_nway.sv
// N-way traffic light controller: Moore FSM GREEN -> YELLOW -> ALLRED with round-robin right of way.
// Optional pedestrian walk support is enabled by defining TLC_PED_EN.
module tlc_nway #(
   parameter int N_WAYS    = 4,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 16,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_WAYS-1:0]         car,
`ifdef TLC_PED_EN
   input  logic [N_WAYS-1:0]         ped_req,
   output logic [N_WAYS-1:0]         walk,
`endif
   output logic [N_WAYS-1:0]         lights_red,
   output logic [N_WAYS-1:0]         lights_yellow,
   output logic [N_WAYS-1:0]         lights_green,
   output logic [$clog2(N_WAYS)-1:0] active_way,
   output logic [1:0]                phase
);

   localparam int AW   = $clog2(N_WAYS);
   localparam int TW   = $clog2(((GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T) + 1);
   localparam int CMAX = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [TW-1:0] GMIN_M1 = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] GMAX_M1 = TW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);
   localparam logic [N_WAYS-1:0] ONE = N_WAYS'(1);

   typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} state_t;

   state_t            state_q;
   logic [AW-1:0]     act_q, next_q, rr_way;
   logic [TW-1:0]     timer_q;
   logic [CW-1:0]     cnt_q;
   logic [N_WAYS-1:0] req_q, req_d;
   logic [N_WAYS-1:0] act_oh, next_oh, ped_set;
   logic              walk_busy, other_req, gap_ok, max_ok, green_exit, enter_green;

`ifdef TLC_PED_EN
   logic [N_WAYS-1:0] ped_q;
   logic              walk_on_q;
   assign ped_set   = ped_req;
   assign walk_busy = walk_on_q && (state_q == GREEN) && (timer_q < TW'(WALK_T));
   assign walk      = walk_busy ? act_oh : '0;
`else
   assign ped_set   = '0;
   assign walk_busy = 1'b0;
`endif

   assign act_oh    = ONE << act_q;
   assign next_oh   = ONE << next_q;
   assign other_req = |(req_q & ~act_oh);
   // Walk service holds the green even when the approach empties.
   assign gap_ok    = (timer_q >= GMIN_M1) && !car[act_q] && !walk_busy;
   assign max_ok    = (timer_q == GMAX_M1);
   assign green_exit  = (state_q == GREEN) && other_req && (gap_ok || max_ok);
   assign enter_green = ((state_q == YELLOW) && (cnt_q == YEL_M1) && (ALLRED_T == 0)) ||
                        ((state_q == ALLRED) && (cnt_q == AR_M1));

   always_comb begin
      logic [AW-1:0] idx;
      logic          found;
      rr_way = act_q;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k < N_WAYS; k++) begin
         idx = AW'((int'(act_q) + k) % N_WAYS);
         if (!found && req_q[idx]) begin
            rr_way = idx;
            found  = 1'b1;
         end
      end
   end

   // The green way ignores its own car input; entry into green clears that way's request.
   always_comb begin
      req_d = req_q | ped_set | (car & ~((state_q == GREEN) ? act_oh : '0));
      if (enter_green) req_d = req_d & ~next_oh;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= GREEN;
         act_q   <= '0;
         next_q  <= '0;
         timer_q <= '0;
         cnt_q   <= '0;
         req_q   <= '0;
`ifdef TLC_PED_EN
         ped_q     <= '0;
         walk_on_q <= 1'b0;
`endif
      end else begin
         req_q <= req_d;
         case (state_q)
            GREEN: begin
               if (green_exit) begin
                  state_q <= YELLOW;
                  cnt_q   <= '0;
                  next_q  <= rr_way;
               end else if (timer_q != GMAX_M1) begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            YELLOW: begin
               if (cnt_q == YEL_M1) begin
                  state_q <= ALLRED;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ALLRED:  cnt_q <= cnt_q + CW'(1);
            default: state_q <= GREEN;
         endcase
         if (enter_green) begin
            state_q <= GREEN;
            act_q   <= next_q;
            timer_q <= '0;
            cnt_q   <= '0;
         end
`ifdef TLC_PED_EN
         ped_q <= enter_green ? ((ped_q | ped_req) & ~next_oh) : (ped_q | ped_req);
         if (enter_green) walk_on_q <= |((ped_q | ped_req) & next_oh);
`endif
      end
   end

   always_comb begin
      lights_red    = '1;
      lights_yellow = '0;
      lights_green  = '0;
      if (state_q == GREEN) begin
         lights_green = act_oh;
         lights_red   = ~act_oh;
      end else if (state_q == YELLOW) begin
         lights_yellow = act_oh;
         lights_red    = ~act_oh;
      end
   end

   assign active_way = act_q;
   assign phase      = state_q;

endmodule

// File: tb/tb_tlc_nway.sv
// Scoreboard bench for tlc_nway: a countdown-based reference model predicts every cycle's outputs.
module tb_tlc_nway;
   localparam int N = 4, GMIN = 4, GMAX = 16, YT = 2, AT = 1, WT = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] car, ped;
   logic [N-1:0] red, yel, grn, walk;
   logic [1:0]   act, phase;

   always #5 clk = ~clk;

   tlc_nway #(.N_WAYS(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT),
              .ALLRED_T(AT), .WALK_T(WT)) dut (
      .clk(clk), .reset(reset), .car(car),
`ifdef TLC_PED_EN
      .ped_req(ped), .walk(walk),
`endif
      .lights_red(red), .lights_yellow(yel), .lights_green(grn),
      .active_way(act), .phase(phase));
`ifndef TLC_PED_EN
   assign walk = '0;
`endif

   typedef struct packed {
      logic [N-1:0] r, y, g, w;
      logic [1:0]   a, p;
   } exp_t;
   exp_t q[$];

   int checks = 0, passes = 0;

   // Model state: phase, green way, cycles already spent green, cycles left in yellow/allred.
   int m_phase, m_act, m_gc, m_left, m_next;
   bit m_walk;
   bit m_req[N], m_pedf[N];

   task automatic enter_green(ref bit nreq[N], ref bit npedf[N]);
      m_phase = 0; m_act = m_next; m_gc = 0;
      nreq[m_next] = 0;
      m_walk = npedf[m_next];
      npedf[m_next] = 0;
   endtask

   task automatic model_step(input logic [N-1:0] c, input logic [N-1:0] p, input logic r);
      bit nreq[N], npedf[N];
      bit others, gap, maxo;
      if (r) begin
         m_phase = 0; m_act = 0; m_gc = 0; m_left = 0; m_next = 0; m_walk = 0;
         for (int i = 0; i < N; i++) begin m_req[i] = 0; m_pedf[i] = 0; end
         return;
      end
      for (int i = 0; i < N; i++) begin
         nreq[i]  = m_req[i] || (c[i] && !(m_phase == 0 && m_act == i)) || p[i];
         npedf[i] = m_pedf[i] || p[i];
      end
      case (m_phase)
         0: begin
            others = 0;
            for (int i = 0; i < N; i++) if (i != m_act && m_req[i]) others = 1;
            gap  = (m_gc >= GMIN - 1) && !c[m_act] && !(m_walk && m_gc < WT);
            maxo = (m_gc >= GMAX - 1);
            if (others && (gap || maxo)) begin
               for (int k = N - 1; k >= 1; k--)
                  if (m_req[(m_act + k) % N]) m_next = (m_act + k) % N;
               m_phase = 1; m_left = YT;
            end else if (m_gc < GMAX - 1) begin
               m_gc++;
            end
         end
         1: begin
            m_left--;
            if (m_left == 0) begin
               if (AT > 0) begin m_phase = 2; m_left = AT; end
               else enter_green(nreq, npedf);
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) enter_green(nreq, npedf);
         end
      endcase
      m_req = nreq;
      m_pedf = npedf;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.r = '1; e.y = '0; e.g = '0; e.w = '0;
      if (m_phase != 2) begin
         e.r[m_act] = 1'b0;
         if (m_phase == 0) e.g[m_act] = 1'b1;
         else e.y[m_act] = 1'b1;
      end
      if (m_phase == 0 && m_walk && m_gc < WT) e.w[m_act] = 1'b1;
      e.a = 2'(m_act);
      e.p = 2'(m_phase);
      return e;
   endfunction

   task automatic tick(input logic [N-1:0] c, input logic [N-1:0] p, input logic r);
      car = c; ped = p; reset = r;
      @(posedge clk);
      model_step(c, p, r);
      #1;
      q.push_back(model_out());
   endtask

   initial begin
      exp_t e, got;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            got = {red, yel, grn, walk, act, phase};
            checks++;
            if (got === e) passes++;
            else $display("FAIL outputs t=%0t got r=%b y=%b g=%b w=%b way=%0d ph=%0d want r=%b y=%b g=%b w=%b way=%0d ph=%0d",
                          $time, got.r, got.y, got.g, got.w, got.a, got.p,
                          e.r, e.y, e.g, e.w, e.a, e.p);
         end
      end
   end

   initial begin
      logic [N-1:0] c, p;
      int n, dens;
      car = '0; ped = '0; reset = 1'b1;
      tick('0, '0, 1); tick('0, '0, 1);
      repeat (50) tick('0, '0, 0);

      tick('0, '0, 1);
      for (int i = 0; i < 30; i++) tick((i == 10) ? 4'b0100 : 4'b0000, '0, 0);

      tick(4'b0011, '0, 1);
      repeat (60) tick(4'b0011, '0, 0);

      tick('0, '0, 1);
      for (int i = 0; i < 40; i++)
         tick((i == 0) ? 4'b1000 : (i == 1) ? 4'b0010 : 4'b0000, '0, 0);

      // Reset landing in the second yellow cycle with another request still pending.
      tick('0, '0, 1);
      tick(4'b0010, '0, 0);
      n = 0;
      while (!(m_phase == 1 && m_left == YT - 1) && n < 100) begin
         tick((m_phase == 1) ? 4'b1000 : 4'b0000, '0, 0);
         n++;
      end
      if (n >= 100) begin
         checks++;
         $display("FAIL yellow_wait got no second yellow cycle within %0d cycles, want one", n);
      end
      tick(4'b1000, '0, 1);
      repeat (25) tick('0, '0, 0);

`ifdef TLC_PED_EN
      tick('0, '0, 1);
      tick('0, 4'b0010, 0);
      repeat (30) tick('0, '0, 0);
`endif

      for (int seg = 0; seg < 15; seg++) begin
         dens = $urandom_range(1, 8);
         for (int i = 0; i < 200; i++) begin
            c = '0; p = '0;
            for (int b = 0; b < N; b++) begin
               c[b] = ($urandom_range(0, 15) < dens);
`ifdef TLC_PED_EN
               p[b] = ($urandom_range(0, 63) == 0);
`endif
            end
            tick(c, p, ($urandom_range(0, 299) == 0));
         end
      end

      @(negedge clk); #1;
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain got %0d unchecked entries, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
